uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial (UART) receiver. Format is 8N1: 1 start bit, 8 data bits sent LSB first, no parity, 1 stop bit.
- Oversamples the raw line with the system clock and samples each bit at its centre.
- Outputs the received byte with a one-cycle valid strobe.
- Sits between an external RX pin and any byte-consuming logic (FIFO, command parser).

Parameters:
- BAUD_RATE, 9600, line bit rate in bits/s.
- CLOCK_FREQ, 50000000, clk frequency in Hz.
- Derived localparam CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer-truncated; 5208 at defaults.
- Derived localparam HALF_BIT = CLKS_PER_BIT / 2.
- Counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-low (rst = 0 resets).
- uart_rxd  input  1  raw asynchronous serial line; idles high.
- uart_rx_valid  output  1  one-cycle pulse: uart_rx_data holds a newly received good byte.
- uart_rx_data  output  8  last correctly framed byte; held stable between pulses.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE; counters = 0; shift register = 0.
  - uart_rx_valid = 0; uart_rx_data = 8'h00.
  - Synchroniser flops = 1. Reset mid-frame abandons the frame, with no valid pulse.
- Input synchroniser: two-flop chain on uart_rxd. All decisions use the synchronised bit rxs.
- IDLE: on rxs = 0, go to START and clear the baud counter.
- START:
  - Count to HALF_BIT-1, then re-check rxs.
  - rxs = 0: valid start bit; go to DATA, clear the counter and bit index.
  - rxs = 1: glitch; return to IDLE.
- DATA:
  - Every CLKS_PER_BIT clocks, shift rxs in MSB-side (shift-right). The first received bit ends up at bit 0.
  - After the 8th sample (bit index 7), go to STOP.
- STOP: after CLKS_PER_BIT clocks, sample rxs.
  - rxs = 1: load uart_rx_data from the shift register in that cycle, pulse uart_rx_valid high for exactly one clock, go to IDLE.
  - rxs = 0 (framing error): no load, no pulse; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs = 1, then go to IDLE. This prevents a break condition from being taken as a start bit.
- Latency: from the start-bit falling edge at the pin to the valid pulse = 2 (sync) + HALF_BIT + 9 × CLKS_PER_BIT clocks, ±1.
- Timing tolerance: with centre sampling, the bench's bit period may deviate ≤ ±2 % from CLKS_PER_BIT clocks.
- uart_rx_valid is never asserted in two consecutive cycles.
- Back-to-back frames: a start bit immediately after the stop-bit sample is detected.
  - The stop sample falls mid-stop-bit, so IDLE is re-entered about half a bit early.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - Adds output port uart_rx_frame_err (1 bit).
  - Pulses high for one clock when the stop-bit sample is 0.
  - Resets to 0.
  - Also a glitch-rejected start in START pulses it only if the filter rejects... no: only stop-bit errors pulse it.
- Undefined: port absent; framing errors are silently dropped. All other behaviour is identical.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
  - localparam DATA_BITS = 8.
  - Helper function clks_per_bit(clock_freq, baud_rate).
- Natural sub-module: uart_rx_sync, the 2-flop synchroniser with reset value 1. Everything else is in uart_rx.

Test Plan:
- Reset: hold rst = 0 for 5 clocks with uart_rxd = 1 → uart_rx_valid = 0, uart_rx_data = 8'h00, no pulses for 20000 clocks after release.
- Single byte: send 8'hA5 with a bit period of 5208 clocks (bits 1,0,1,0,0,1,0,1 after the start bit) → exactly one valid pulse, uart_rx_data = 8'hA5, pulse about 49480 clocks after the start edge.
- Back-to-back: send 8'h00, 8'hFF, 8'h55 with no idle gap → three pulses with data 00, FF, 55 in order.
- Glitch: drive uart_rxd low for 1000 clocks, then high → no valid pulse; the next frame 8'h3C is received correctly.
- Framing error: send 8'hC3 with the stop bit held low for 2 bit times, then high → no pulse; uart_rx_data keeps its previous value; the frame_err pulse appears if UART_RX_FRAME_ERR_EN is defined; the following frame 8'h81 is received.
- Mid-frame reset: assert rst after 4 data bits of 8'hF0, release, then send 8'h1E → only one pulse, with 8'h1E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver slice.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw RX line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling and a one-cycle valid strobe.
// Define UART_RX_FRAME_ERR_EN to add the uart_rx_frame_err pulse output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_FREQ = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic                 uart_rx_valid,
`ifdef UART_RX_FRAME_ERR_EN
    output logic                 uart_rx_frame_err,
`endif
    output logic [DATA_BITS-1:0] uart_rx_data
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rxd),
        .q_o (rxs)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shifting right leaves it at bit 0
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign uart_rx_valid = valid_q;
    assign uart_rx_data  = data_q;

`ifdef UART_RX_FRAME_ERR_EN
    assign uart_rx_frame_err = ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised/directed bench for uart_rx; expected bytes come from a queue model.
// Honours UART_RX_FRAME_ERR_EN when the design is built with it.
module tb_uart_rx;

    localparam int unsigned BAUD   = 50000;
    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned CPB    = CLK_HZ / BAUD;
    localparam int unsigned HALF   = CPB / 2;
    localparam int unsigned LAT    = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       valid;
    logic [7:0] data;
`ifdef UART_RX_FRAME_ERR_EN
    logic       ferr;
    int         ferr_cnt = 0;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    int         consec      = 0;
    logic       prev_valid  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    time        got_t[$];
    time        start_t;

    uart_rx #(
        .BAUD_RATE  (BAUD),
        .CLOCK_FREQ (CLK_HZ)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_rxd          (rxd),
        .uart_rx_valid     (valid),
`ifdef UART_RX_FRAME_ERR_EN
        .uart_rx_frame_err (ferr),
`endif
        .uart_rx_data      (data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            got_q.push_back(data);
            got_t.push_back($time);
            if (prev_valid) consec <= consec + 1;
        end
        prev_valid <= valid;
`ifdef UART_RX_FRAME_ERR_EN
        if (ferr) ferr_cnt <= ferr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after n clocks.
    task automatic drive_bit(input logic b, input int unsigned n);
        rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        start_t = $time;
        if (good) exp_q.push_back(b);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (good) begin
            drive_bit(1'b1, CPB);
        end else begin
            drive_bit(1'b0, 2 * CPB);
            drive_bit(1'b1, CPB);
        end
    endtask

    task automatic settle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        got_t.delete();
    endtask

    initial begin
        int unsigned lat;
        logic [7:0]  rb;

        // Reset
        rst = 1'b0;
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 8'h00);
        rst = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        check("idle_pulses", got_q.size(), 0);
        check("idle_data", data, 8'h00);

        // Single byte with latency
        send_frame(8'hA5, 1'b1);
        if (got_t.size() > 0) begin
            lat = int'((got_t[0] - 5 - (start_t - 1)) / 10);
            check("latency", (lat + 1 >= LAT && lat <= LAT + 1) ? LAT : lat, LAT);
        end else begin
            check("latency_pulse_seen", 0, 1);
        end
        settle("single", 4 * CPB);

        // Back-to-back
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        settle("b2b", 4 * CPB);

        // Short glitch shorter than half a bit
        drive_bit(1'b0, HALF / 2);
        drive_bit(1'b1, 3 * CPB);
        check("glitch_pulses", got_q.size(), 0);
        send_frame(8'h3C, 1'b1);
        settle("glitch", 4 * CPB);

        // Framing error: stop held low
        send_frame(8'hC3, 1'b0);
        drive_bit(1'b1, 2 * CPB);
        check("ferr_pulses", got_q.size(), 0);
        check("ferr_hold", data, 8'h3C);
`ifdef UART_RX_FRAME_ERR_EN
        check("ferr_strobe", ferr_cnt, 1);
`endif
        send_frame(8'h81, 1'b1);
        settle("after_ferr", 4 * CPB);

        // Random bytes with random idle gaps
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1);
            drive_bit(1'b1, $urandom_range(0, CPB));
        end
        settle("random", 8 * CPB);

        // Reset in the middle of a frame
        rb = 8'hF0;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(rb[i], CPB);
        rxd = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_valid", valid, 1'b0);
        check("midrst_data", data, 8'h00);
        rst = 1'b1;
        drive_bit(1'b1, 3 * CPB);
        send_frame(8'h1E, 1'b1);
        settle("midrst", 4 * CPB);

        check("valid_consecutive", consec, 0);
`ifdef UART_RX_FRAME_ERR_EN
        check("ferr_total", ferr_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
